// File: rtl/alu_pkg.sv
// Constants, opcodes and FSM encoding shared by the arbiter and the 4-bit ALU.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] ALU_ADD    = 3'b000;
  localparam logic [SEL_W-1:0] ALU_SUB    = 3'b001;
  localparam logic [SEL_W-1:0] ALU_AND    = 3'b010;
  localparam logic [SEL_W-1:0] ALU_OR     = 3'b011;
  localparam logic [SEL_W-1:0] ALU_XOR    = 3'b100;
  localparam logic [SEL_W-1:0] ALU_NOT_A  = 3'b101;
  localparam logic [SEL_W-1:0] ALU_PASS_B = 3'b110;
  localparam logic [SEL_W-1:0] ALU_PASS_A = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu4bit.sv
// Purely combinational ALU: a, b, sel -> result, carry (add carry-out / sub borrow), zero.
module alu4bit #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int SEL_W  = alu_pkg::SEL_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);
  import alu_pkg::*;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // The extra top bit of the widened difference is the borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = a;
    carry  = 1'b0;
    case (sel)
      ALU_ADD:    begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
      ALU_SUB:    begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_NOT_A:  result = ~a;
      ALU_PASS_B: result = b;
      default:    result = a;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one alu4bit between two valid/ready requesters,
// returning a tagged, registered result on a single response channel.
module alu_req_arbiter #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int SEL_W  = alu_pkg::SEL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  input  logic [2*SEL_W-1:0]    req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_zero,
  output logic                  busy
);
  import alu_pkg::*;

  state_t              state_reg, state_next;
  logic                last_grant_reg;
  logic                grant;
  logic                accept;
  logic [DATA_W-1:0]   a_reg, b_reg;
  logic [SEL_W-1:0]    sel_reg;
  logic                id_reg;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry, alu_zero;

  alu4bit #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .sel    (sel_reg),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // On a tie the requester that did not win last time gets the grant.
  assign grant  = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];
  assign accept = (state_reg == IDLE) && (|req_valid);
  assign busy   = (state_reg != IDLE);

  always_comb begin
    req_ready  = 2'b00;
    state_next = state_reg;
    if (accept) req_ready[grant] = 1'b1;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      sel_reg        <= '0;
      id_reg         <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_result     <= '0;
      rsp_carry      <= 1'b0;
      rsp_zero       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg          <= grant ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        b_reg          <= grant ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
        sel_reg        <= grant ? req_sel[2*SEL_W-1:SEL_W] : req_sel[SEL_W-1:0];
        id_reg         <= grant;
        last_grant_reg <= grant;
      end
      if (state_reg == EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= id_reg;
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
      end else if (state_reg == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: opcode table, fairness, backpressure and reset-abort sequences.
module tb_alu_req_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready;
  logic [7:0] req_a, req_b;
  logic [5:0] req_sel;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, busy;
  logic [3:0] rsp_result;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_req_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] res;
    logic       carry;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] sel);
    if (id) begin
      req_a[7:4] = a; req_b[7:4] = b; req_sel[5:3] = sel;
    end else begin
      req_a[3:0] = a; req_b[3:0] = b; req_sel[2:0] = sel;
    end
  endtask

  // Waits (bounded) for any ready bit, then checks which one it is.
  task automatic wait_ready(input logic [1:0] exp, input string name);
    int k = 0;
    while (req_ready == 2'b00 && k < 10) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, {30'd0, req_ready}, {30'd0, exp});
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    logic [1:0] onehot;
    string      tag;
    onehot = v.id ? 2'b10 : 2'b01;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(v.id, v.a, v.b, v.sel);
    req_valid = onehot;
    #1;
    wait_ready(onehot, {tag, "_ready"});
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_exec_rspv"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); #1;
    chk({tag, "_rspv"},   {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_id"},     {31'd0, rsp_id}, {31'd0, v.id});
    chk({tag, "_result"}, {28'd0, rsp_result}, {28'd0, v.res});
    chk({tag, "_carry"},  {31'd0, rsp_carry}, {31'd0, v.carry});
    chk({tag, "_zero"},   {31'd0, rsp_zero}, {31'd0, (v.res == 4'd0)});
    @(negedge clk); #1;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_rspv"}, {31'd0, rsp_valid}, 32'd0);
    $display("vec%0d id=%0d a=%h b=%h sel=%b -> result=%h carry=%0d", idx, v.id, v.a, v.b,
             v.sel, rsp_result, rsp_carry);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a0, a1, exp_res;
    logic       exp_id;

    //          id    a      b      sel     res    carry
    vecs[0]  = '{1'b0, 4'h3, 4'h5, 3'b000, 4'h8, 1'b0};
    vecs[1]  = '{1'b1, 4'h2, 4'h4, 3'b001, 4'hE, 1'b1};
    vecs[2]  = '{1'b1, 4'h8, 4'h2, 3'b001, 4'h6, 1'b0};
    vecs[3]  = '{1'b0, 4'hF, 4'h1, 3'b000, 4'h0, 1'b1};
    vecs[4]  = '{1'b0, 4'hC, 4'hC, 3'b100, 4'h0, 1'b0};
    vecs[5]  = '{1'b1, 4'hC, 4'h9, 3'b101, 4'h3, 1'b0};
    vecs[6]  = '{1'b0, 4'h4, 4'hF, 3'b110, 4'hF, 1'b0};
    vecs[7]  = '{1'b1, 4'hA, 4'h5, 3'b111, 4'hA, 1'b0};
    vecs[8]  = '{1'b0, 4'hC, 4'hA, 3'b010, 4'h8, 1'b0};
    vecs[9]  = '{1'b1, 4'hC, 4'hA, 3'b011, 4'hE, 1'b0};
    vecs[10] = '{1'b0, 4'h5, 4'h5, 3'b001, 4'h0, 1'b0};

    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rspv",   {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_ready",  {30'd0, req_ready}, 32'd0);
    chk("rst_id",     {31'd0, rsp_id}, 32'd0);
    chk("rst_result", {28'd0, rsp_result}, 32'd0);
    chk("rst_carry",  {31'd0, rsp_carry}, 32'd0);
    chk("rst_zero",   {31'd0, rsp_zero}, 32'd0);
    $display("reset state checked");

    foreach (vecs[i]) do_vec(vecs[i], i);

    // Fairness: both requesters valid straight out of reset, grants must alternate from 0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a0 = 4'h1; a1 = 4'hE;
    drive(1'b0, a0, 4'h1, 3'b000);
    drive(1'b1, a1, 4'h0, 3'b111);
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_id = i[0];
      exp_res = exp_id ? a1 : a0 + 4'h1;
      wait_ready(exp_id ? 2'b10 : 2'b01, $sformatf("fair%0d_ready", i));
      @(negedge clk);
      if (exp_id) begin a1 = a1 - 4'h2; drive(1'b1, a1, 4'h0, 3'b111); end
      else begin a0 = a0 + 4'h3; drive(1'b0, a0, 4'h1, 3'b000); end
      @(negedge clk); #1;
      chk($sformatf("fair%0d_rspv", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("fair%0d_id", i), {31'd0, rsp_id}, {31'd0, exp_id});
      chk($sformatf("fair%0d_result", i), {28'd0, rsp_result}, {28'd0, exp_res});
      $display("fair%0d grant=%0d result=%h", i, rsp_id, rsp_result);
      @(negedge clk); #1;
    end
    req_valid = 2'b00;

    // Backpressure: response held for 5 cycles with requester 1 waiting.
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, 4'hF, 4'h6, 3'b010);
    req_valid = 2'b01;
    #1;
    wait_ready(2'b01, "bp_ready");
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    chk("bp_exec_ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk); #1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("bp%0d_rspv", j), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_result", j), {28'd0, rsp_result}, 32'h6);
      chk($sformatf("bp%0d_id", j), {31'd0, rsp_id}, 32'd0);
      chk($sformatf("bp%0d_ready", j), {30'd0, req_ready}, 32'd0);
      chk($sformatf("bp%0d_busy", j), {31'd0, busy}, 32'd1);
      $display("bp stall cycle %0d rsp_valid=%0d result=%h", j, rsp_valid, rsp_result);
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge clk); #1;
    chk("bp_done_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("bp_done_busy", {31'd0, busy}, 32'd0);
    $display("bp released, rsp_valid=%0d busy=%0d", rsp_valid, busy);

    // Reset during EXEC drops the operation.
    @(negedge clk);
    drive(1'b0, 4'h1, 4'h2, 3'b000);
    req_valid = 2'b01;
    #1;
    wait_ready(2'b01, "rx_ready");
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rx_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rx_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    chk("rx_norsp", {31'd0, rsp_valid}, 32'd0);
    $display("reset in EXEC: rsp_valid=%0d busy=%0d", rsp_valid, busy);

    // Reset during RESP drops the pending response; tie then goes to requester 0.
    req_valid = 2'b01;
    #1;
    wait_ready(2'b01, "rr_ready");
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    chk("rr_pre_rspv", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rr_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    drive(1'b1, 4'h9, 4'h0, 3'b111);
    req_valid = 2'b11;
    #1;
    chk("rr_tie_grant", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk); #1;
    chk("rr_after_id", {31'd0, rsp_id}, 32'd0);
    chk("rr_after_result", {28'd0, rsp_result}, 32'h3);
    $display("reset in RESP: next grant id=%0d result=%h", rsp_id, rsp_result);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
